// File: rtl/fft_ctrl_pkg.sv
// Shared types and helpers for the radix-2 in-place FFT memory sequencer.
package fft_ctrl_pkg;

  localparam int S = 5;
  localparam int N = 1 << S;
  localparam int D = 3;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, UNLOAD} fft_state_e;

  function automatic logic [15:0] bitrev(input logic [15:0] a, input int w);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      if (i < w) r[w-1-i] = a[i];
    return r;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Butterfly address/twiddle generator: (stage, k, ph) -> RAM address and twiddle index.
module fft_addr_gen #(
  parameter int ADDR_W = 5,
  parameter int STG_W  = 3
) (
  input  logic [STG_W-1:0]  stage,
  input  logic [ADDR_W-2:0] k,
  input  logic              ph,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-2:0] tw_idx
);

  int                sh;
  logic [ADDR_W-1:0] kx, span, j, grp, a;

  // span = N >> (stage+1) = 1 << (ADDR_W-1-stage)
  always_comb begin
    sh     = ADDR_W - 1 - int'(stage);
    kx     = {1'b0, k};
    span   = ADDR_W'(1) << sh;
    j      = kx & (span - ADDR_W'(1));
    grp    = kx >> sh;
    a      = (grp << (sh + 1)) | j;
    addr   = ph ? a + span : a;
    tw_idx = (ADDR_W-1)'(j << stage);
  end

endmodule

// File: rtl/fft_r2_mem_ctrl.sv
// In-place radix-2 DIF FFT sequencer over a simple dual-port RAM.
// Define FFT_OUT_BITREV_EN to unload in natural (bit-reversed address) order.
module fft_r2_mem_ctrl
  import fft_ctrl_pkg::*;
#(
  parameter int ADDR_W = S,
  parameter int BF_LAT = D - 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       ram_valid,
  output logic                       ram_we,
  output logic                       ram_re,
  output logic [ADDR_W-1:0]          ram_addr_w,
  output logic [ADDR_W-1:0]          ram_addr_r,
  output logic                       wr_sel,
  output logic                       bf_op,
  output logic                       bf_en,
  output logic [ADDR_W-2:0]          tw_idx,
  output logic [$clog2(ADDR_W)-1:0]  stage
);

  localparam int NP    = 1 << ADDR_W;
  localparam int ND    = 1 + BF_LAT;
  localparam int STG_W = $clog2(ADDR_W);
  localparam int KW    = ADDR_W - 1;
  localparam int DW    = (ND > 1) ? $clog2(ND) : 1;

  fft_state_e                   state;
  logic [ADDR_W:0]              cnt;
  logic [KW-1:0]                k;
  logic                         ph;
  logic [DW-1:0]                dcnt;
  logic [ADDR_W-1:0]            gen_addr;
  logic [KW-1:0]                gen_tw;
  logic                         run_rd, ld_we, ul_re;
  logic [ADDR_W-1:0]            ul_addr;
  logic [ND-1:0]                vld_pipe;
  logic [ND-1:0][ADDR_W-1:0]    addr_pipe;

  fft_addr_gen #(.ADDR_W(ADDR_W), .STG_W(STG_W)) u_addr_gen (
    .stage  (stage),
    .k      (k),
    .ph     (ph),
    .addr   (gen_addr),
    .tw_idx (gen_tw)
  );

  assign run_rd = (state == RUN);
  assign ld_we  = (state == LOAD) && in_valid;
  assign ul_re  = (state == UNLOAD) && !cnt[ADDR_W] && (!out_valid || out_ready);

`ifdef FFT_OUT_BITREV_EN
  assign ul_addr = ADDR_W'(bitrev(16'(cnt[ADDR_W-1:0]), ADDR_W));
`else
  assign ul_addr = cnt[ADDR_W-1:0];
`endif

  assign in_ready   = (state == LOAD);
  assign busy       = (state != IDLE);
  assign ram_re     = run_rd | ul_re;
  assign ram_we     = ld_we | vld_pipe[ND-1];
  assign ram_valid  = ram_re | ram_we;
  assign ram_addr_r = run_rd ? gen_addr : (ul_re ? ul_addr : '0);
  assign ram_addr_w = ld_we ? cnt[ADDR_W-1:0] : (vld_pipe[ND-1] ? addr_pipe[ND-1] : '0);
  assign wr_sel     = (state == RUN) || (state == DRAIN);
  assign bf_en      = run_rd;
  assign bf_op      = run_rd & ph;
  assign tw_idx     = (run_rd && !ph) ? gen_tw : '0;

  // Write-back delay line: each butterfly read retires as an in-place write D cycles later.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
    end else begin
      vld_pipe     <= ND'({vld_pipe, run_rd});
      addr_pipe[0] <= gen_addr;
      for (int i = 1; i < ND; i++) addr_pipe[i] <= addr_pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      k         <= '0;
      ph        <= 1'b0;
      dcnt      <= '0;
      stage     <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          cnt   <= '0;
        end
        LOAD: if (in_valid) begin
          cnt <= cnt + (ADDR_W+1)'(1);
          if (cnt == (ADDR_W+1)'(NP-1)) begin
            state <= RUN;
            stage <= '0;
            k     <= '0;
            ph    <= 1'b0;
          end
        end
        RUN: begin
          ph <= ~ph;
          if (ph) begin
            k <= k + KW'(1);
            if (k == '1) begin
              state <= DRAIN;
              dcnt  <= '0;
            end
          end
        end
        // Hold off the next stage's reads until every pending write has landed
        DRAIN: begin
          dcnt <= dcnt + DW'(1);
          if (dcnt == DW'(ND-1)) begin
            if (stage == STG_W'(ADDR_W-1)) begin
              state <= UNLOAD;
              cnt   <= '0;
            end else begin
              state <= RUN;
              stage <= stage + STG_W'(1);
              k     <= '0;
              ph    <= 1'b0;
            end
          end
        end
        UNLOAD: begin
          if (ul_re) begin
            cnt       <= cnt + (ADDR_W+1)'(1);
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
          if (out_valid && out_ready && cnt[ADDR_W]) begin
            state     <= IDLE;
            done      <= 1'b1;
            out_valid <= 1'b0;
            cnt       <= '0;
            stage     <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_r2_mem_ctrl.sv
// Scoreboard bench for fft_r2_mem_ctrl with a behavioural RAM and integer butterfly.
module tb_fft_r2_mem_ctrl;

  localparam int AW = 5;
  localparam int NP = 32;
  localparam int NS = 5;

  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, busy, done, ram_valid, ram_we, ram_re, wr_sel, bf_op, bf_en;
  logic [AW-1:0] ram_addr_w, ram_addr_r;
  logic [AW-2:0] tw_idx;
  logic [2:0]    stage;

  always #5 clk = ~clk;

  fft_r2_mem_ctrl dut (
    .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
    .ram_valid(ram_valid), .ram_we(ram_we), .ram_re(ram_re), .ram_addr_w(ram_addr_w),
    .ram_addr_r(ram_addr_r), .wr_sel(wr_sel), .bf_op(bf_op), .bf_en(bf_en),
    .tw_idx(tw_idx), .stage(stage)
  );

  // RAM with 1-cycle read latency, plus a DIF butterfly (a+b, a-b) of latency 2
  int   mem [NP];
  int   dout, din, a_hold, bf0, bf1;
  logic en_d, op_d;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr_w] <= wr_sel ? bf0 : din;
    if (ram_re) dout <= mem[ram_addr_r];
    en_d <= bf_en;
    op_d <= bf_op;
    if (en_d && !op_d) a_hold <= dout;
    if (en_d && op_d) begin
      bf0 <= a_hold + dout;
      bf1 <= a_hold - dout;
    end else begin
      bf0 <= bf1;
    end
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] brv(input logic [4:0] v);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = v[4-i];
    return r;
  endfunction

  typedef struct {
    logic [4:0] addr;
    logic [3:0] tw;
    logic       op;
    logic [2:0] stg;
  } rd_t;

  rd_t        rd_q [$];
  int         out_q [$];
  logic [4:0] ul_q [$];

  // Monitor state
  int         cyc = 0, last_ld = 0, n_acc = 0, frames_done = 0, held = 0;
  logic       ul_seen = 1'b0, done_nxt = 1'b0, hold_pend = 1'b0;
  logic       hv [3] = '{1'b0, 1'b0, 1'b0};
  logic [4:0] ha [3] = '{5'd0, 5'd0, 5'd0};
  rd_t        e;
  logic [4:0] ue;

  always @(negedge clk) begin
    cyc++;
    if (ram_re && bf_en) begin
      if (rd_q.size() == 0) chk("rd_extra", 1, 0);
      else begin
        e = rd_q.pop_front();
        chk("rd_addr", ram_addr_r, e.addr);
        chk("rd_op", bf_op, e.op);
        chk("rd_stage", stage, e.stg);
        if (!e.op) chk("rd_tw", tw_idx, e.tw);
      end
    end
    if (wr_sel) begin
      chk("wb_we", ram_we, hv[2]);
      if (ram_we) chk("wb_addr", ram_addr_w, ha[2]);
    end
    hv[2] = hv[1]; ha[2] = ha[1];
    hv[1] = hv[0]; ha[1] = ha[0];
    hv[0] = ram_re && bf_en; ha[0] = ram_addr_r;
    if (in_ready && ram_we) last_ld = cyc;
    if (ram_re && !bf_en) begin
      if (!ul_seen) begin
        ul_seen = 1'b1;
        chk("run_cyc", cyc - last_ld - 1, 175);
      end
      if (ul_q.size() == 0) chk("ul_extra", 1, 0);
      else begin
        ue = ul_q.pop_front();
        chk("ul_addr", ram_addr_r, ue);
      end
    end
    chk("done", done, done_nxt);
    done_nxt = 1'b0;
    if (hold_pend) begin
      chk("hold_vld", out_valid, 1);
      chk("hold_dat", dout, held);
      hold_pend = 1'b0;
    end
    if (out_valid && out_ready) begin
      if (out_q.size() == 0) chk("out_extra", 1, 0);
      else chk("out_dat", dout, out_q.pop_front());
      n_acc++;
      if (n_acc == NP) begin
        done_nxt = 1'b1;
        n_acc    = 0;
      end
    end else if (out_valid) begin
      hold_pend = 1'b1;
      held      = dout;
    end
    if (done) frames_done++;
  end

  int src [NP];
  int m   [NP];

  task automatic frame(input bit tog);
    int span, a, fd0;
    logic [4:0] ua;
    for (int s = 0; s < NS; s++) begin
      span = NP >> (s + 1);
      for (int g = 0; g < (1 << s); g++)
        for (int j = 0; j < span; j++) begin
          a = g * 2 * span + j;
          rd_q.push_back('{addr: 5'(a), tw: 4'(j << s), op: 1'b0, stg: 3'(s)});
          rd_q.push_back('{addr: 5'(a + span), tw: 4'(j << s), op: 1'b1, stg: 3'(s)});
        end
    end
    for (int i = 0; i < NP; i++) m[i] = src[i];
    for (int s = 0; s < NS; s++) begin
      span = NP >> (s + 1);
      for (int g = 0; g < (1 << s); g++)
        for (int j = 0; j < span; j++) begin
          a = g * 2 * span + j;
          {m[a], m[a+span]} = {m[a] + m[a+span], m[a] - m[a+span]};
        end
    end
    for (int i = 0; i < NP; i++) begin
`ifdef FFT_OUT_BITREV_EN
      ua = brv(5'(i));
`else
      ua = 5'(i);
`endif
      ul_q.push_back(ua);
      out_q.push_back(m[ua]);
    end
    ul_seen = 1'b0;
    fd0 = frames_done;
    out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < NP; i++) begin
      din = src[i];
      @(negedge clk);
      chk("ld_rdy", in_ready, 1);
      chk("ld_we", ram_we, 1);
      chk("ld_addr", ram_addr_w, i);
      chk("ld_sel", wr_sel, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    din = 0;
    repeat (20) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 0; c < 3000 && frames_done == fd0; c++) begin
      @(posedge clk); #1;
      out_ready = tog ? ~out_ready : 1'b1;
    end
    if (frames_done == fd0) chk("timeout", 0, 1);
    @(negedge clk);
    chk("end_busy", busy, 0);
    chk("end_rdq", rd_q.size(), 0);
    chk("end_outq", out_q.size(), 0);
    chk("end_ulq", ul_q.size(), 0);
  endtask

  initial begin
    din = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {in_ready, out_valid, busy, done, ram_valid, ram_we, ram_re, ram_addr_w,
                     ram_addr_r, wr_sel, bf_op, bf_en, tw_idx, stage}, 0);
    rstn = 1'b1;
    // Abort a frame with reset mid-LOAD
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; in_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("ld_busy", busy, 1);
    rstn = 1'b0;
    #1;
    chk("ar_busy", busy, 0);
    chk("ar_inrdy", in_ready, 0);
    chk("ar_we", ram_we, 0);
    @(posedge clk); #1 rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_we", ram_we, 0);
      chk("post_rst_busy", busy, 0);
    end
    in_valid = 1'b0;
    // Impulse frame, free-flowing output
    for (int i = 0; i < NP; i++) src[i] = 0;
    src[0] = 1;
    frame(1'b0);
    // Random frame with out_ready toggling
    for (int i = 0; i < NP; i++) src[i] = int'($urandom_range(1000)) - 500;
    frame(1'b1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
